// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Immediate generator for the RISC-V decode path, decoupled from execute by
//   a 2-entry result buffer. The immediate is formed combinationally from the
//   incoming instruction bits. It is then written into the buffer together
//   with a user tag and an illegal-select flag.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready. The producer holds its payload stable until that edge and
//   may withdraw valid without penalty. in_ready depends only on the buffer
//   occupancy, never on out_ready. The head outputs stay stable while
//   out_valid && !out_ready.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       upstream offers an instruction
//   in_ready       buffer has room (count < 2)
//   instr_part     instruction bits [31:7]
//   imm_src        format select: I, S, B, U, J, SHAMT; 110/111 are illegal
//   in_tag         tag stored alongside the result
//   out_valid      buffer head holds a result
//   out_ready      downstream accepts the head
//   imm_out        XLEN-bit immediate at the head
//   out_tag        tag at the head
//   imm_illegal    head entry came from an illegal imm_src
//   illegal_cnt    saturating count of accepted illegal selects
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr_part,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // The shift amount is 5 bits for RV32 and 6 bits for RV64.
  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  // Combinational immediate formation at the input.
  logic [XLEN-1:0] imm_calc;
  logic            illegal_calc;
  logic            sgn;

  always_comb begin
    imm_calc     = '0;
    illegal_calc = 1'b0;
    sgn          = instr_part[31];
    case (imm_src)
      3'b000: imm_calc = {{(XLEN-12){sgn}}, instr_part[31:20]};
      3'b001: imm_calc = {{(XLEN-12){sgn}}, instr_part[31:25], instr_part[11:7]};
      3'b010: imm_calc = {{(XLEN-12){sgn}}, instr_part[7], instr_part[30:25],
                          instr_part[11:8], 1'b0};
      // Bit 31 comes from the sign replication, so the replicated field is
      // never empty even when XLEN is 32.
      3'b011: imm_calc = {{(XLEN-31){sgn}}, instr_part[30:12], 12'b0};
      3'b100: imm_calc = {{(XLEN-20){sgn}}, instr_part[19:12], instr_part[20],
                          instr_part[30:21], 1'b0};
      3'b101: imm_calc = {{(XLEN-SH_W){1'b0}}, instr_part[20+SH_W-1:20]};
      default: begin
        imm_calc     = '0;
        illegal_calc = 1'b1;
      end
    endcase
  end

  // Buffer state.
  logic [XLEN-1:0]  imm_mem_q [2];
  logic [XLEN-1:0]  imm_mem_d [2];
  logic [TAG_W-1:0] tag_mem_q [2];
  logic [TAG_W-1:0] tag_mem_d [2];
  logic             ill_mem_q [2];
  logic             ill_mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic push;
  logic pop;

  assign in_ready    = (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  // The head is always read from registered state, so there is no path from
  // any input to these outputs.
  assign imm_out     = imm_mem_q[rd_ptr_q];
  assign out_tag     = tag_mem_q[rd_ptr_q];
  assign imm_illegal = ill_mem_q[rd_ptr_q];
  assign illegal_cnt = illegal_cnt_q;

  always_comb begin
    imm_mem_d     = imm_mem_q;
    tag_mem_d     = tag_mem_q;
    ill_mem_d     = ill_mem_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    illegal_cnt_d = illegal_cnt_q;

    if (push) begin
      imm_mem_d[wr_ptr_q] = imm_calc;
      tag_mem_d[wr_ptr_q] = in_tag;
      ill_mem_d[wr_ptr_q] = illegal_calc;
      wr_ptr_d            = ~wr_ptr_q;
      if (illegal_calc && (illegal_cnt_q != {CNT_W{1'b1}})) begin
        illegal_cnt_d = illegal_cnt_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_mem_q     <= '{default: '0};
      tag_mem_q     <= '{default: '0};
      ill_mem_q     <= '{default: 1'b0};
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      imm_mem_q     <= imm_mem_d;
      tag_mem_q     <= tag_mem_d;
      ill_mem_q     <= ill_mem_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. dut_a is the RV32 / 8-bit counter build
//   and uses a scoreboard. dut_b is the RV64 / 2-bit counter build and is
//   checked inline. Inputs change 1 time unit after a rising edge. The
//   dut_a monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam int W = 1 + 5 + 32;  // {illegal, tag, imm}

  logic clk;
  logic rst;

  // dut_a: XLEN=32, CNT_W=8
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_imm_illegal;
  logic [31:7] a_instr;
  logic [2:0]  a_imm_src;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_imm_out;
  logic [7:0]  a_illegal_cnt;

  // dut_b: XLEN=64, CNT_W=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_imm_illegal;
  logic [31:7] b_instr;
  logic [2:0]  b_imm_src;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [63:0] b_imm_out;
  logic [1:0]  b_illegal_cnt;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr_part(a_instr), .imm_src(a_imm_src), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm_out(a_imm_out), .out_tag(a_out_tag),
    .imm_illegal(a_imm_illegal), .illegal_cnt(a_illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr_part(b_instr), .imm_src(b_imm_src), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm_out(b_imm_out), .out_tag(b_out_tag),
    .imm_illegal(b_imm_illegal), .illegal_cnt(b_illegal_cnt)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int pops_a   = 0;
  int waits_a  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
  endtask

  // Any transfer at the next rising edge must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      check("sb_has_entry", 64'(exp_q.size() > 0), 64'h1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("a_imm", 64'(a_imm_out), 64'(mon_e[31:0]));
        check("a_tag", 64'(a_out_tag), 64'(mon_e[36:32]));
        check("a_illegal", 64'(a_imm_illegal), 64'(mon_e[37]));
        pops_a++;
      end
    end
  end

  // Drivers (called 1 time unit after a rising edge, return the same way)
  task automatic send_a(input logic [2:0] src, input logic [31:0] instr,
                        input logic [4:0] tag, input logic [31:0] exp_imm,
                        input logic exp_ill);
    int waited;
    waited     = 0;
    a_in_valid = 1'b1;
    a_imm_src  = src;
    a_instr    = instr[31:7];
    a_in_tag   = tag;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      waited++;
      waits_a++;
      if (waited > 50) begin
        check("a_in_ready_wait", 64'(a_in_ready), 64'h1);
        break;
      end
    end
    exp_q.push_back({exp_ill, tag, exp_imm});
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] src, input logic [31:0] instr,
                        input logic [4:0] tag, input logic [63:0] exp_imm,
                        input logic exp_ill);
    check("b_in_ready", 64'(b_in_ready), 64'h1);
    b_in_valid = 1'b1;
    b_imm_src  = src;
    b_instr    = instr[31:7];
    b_in_tag   = tag;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check("b_out_valid", 64'(b_out_valid), 64'h1);
    check("b_imm", b_imm_out, exp_imm);
    check("b_tag", 64'(b_out_tag), 64'(tag));
    check("b_illegal", 64'(b_imm_illegal), 64'(exp_ill));
  endtask

  int p0, w0;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_instr = '0; a_imm_src = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_instr = '0; b_imm_src = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'h1);
    check("rst_out_valid", 64'(a_out_valid), 64'h0);
    check("rst_imm_out", 64'(a_imm_out), 64'h0);
    check("rst_out_tag", 64'(a_out_tag), 64'h0);
    check("rst_imm_illegal", 64'(a_imm_illegal), 64'h0);
    check("rst_illegal_cnt", 64'(a_illegal_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // I-type, one-cycle latency
    send_a(3'b000, 32'hFFF00093, 5'd1, 32'hFFFFFFFF, 1'b0);
    check("i_latency_valid", 64'(a_out_valid), 64'h1);
    @(posedge clk);
    #1;

    // Back-to-back formats, one result per cycle
    p0 = pops_a;
    w0 = waits_a;
    send_a(3'b001, 32'h00112623, 5'd2, 32'h0000000C, 1'b0);
    send_a(3'b010, 32'hFE000CE3, 5'd3, 32'hFFFFFFF8, 1'b0);
    send_a(3'b011, 32'h123450B7, 5'd4, 32'h12345000, 1'b0);
    send_a(3'b100, 32'h0010006F, 5'd5, 32'h00000800, 1'b0);
    send_a(3'b101, 32'h03F00013, 5'd6, 32'h0000001F, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_pops", 64'(pops_a - p0), 64'd5);
    check("b2b_no_stall", 64'(waits_a - w0), 64'd0);
    check("b2b_drained", 64'(a_out_valid), 64'h0);

    // Illegal selects
    send_a(3'b111, 32'hFFFFFFFF, 5'd7, 32'h0, 1'b1);
    send_a(3'b111, 32'h12345678, 5'd8, 32'h0, 1'b1);
    send_a(3'b110, 32'h80000000, 5'd9, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("illegal_cnt_3", 64'(a_illegal_cnt), 64'd3);

    // Backpressure: fill, hold a third (illegal) push, then release
    a_out_ready = 1'b0;
    send_a(3'b000, 32'hFFF00093, 5'd10, 32'hFFFFFFFF, 1'b0);
    send_a(3'b001, 32'h00112623, 5'd11, 32'h0000000C, 1'b0);
    check("full_in_ready", 64'(a_in_ready), 64'h0);
    check("full_out_valid", 64'(a_out_valid), 64'h1);
    fork
      send_a(3'b111, 32'h00000013, 5'd12, 32'h0, 1'b1);
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
          check("hold_tag", 64'(a_out_tag), 64'd10);
          check("hold_imm", 64'(a_imm_out), 64'hFFFFFFFF);
          check("hold_in_ready", 64'(a_in_ready), 64'h0);
          check("hold_cnt", 64'(a_illegal_cnt), 64'd3);
        end
        a_out_ready = 1'b1;
        #1;
        check("full_ignores_out_ready", 64'(a_in_ready), 64'h0);
        @(posedge clk);
        #1;
        check("in_ready_after_pop", 64'(a_in_ready), 64'h1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("illegal_cnt_4", 64'(a_illegal_cnt), 64'd4);

    // RV64 build with a 2-bit counter
    send_b(3'b011, 32'h800000B7, 5'd1, 64'hFFFFFFFF80000000, 1'b0);
    send_b(3'b101, 32'h03F00013, 5'd2, 64'h000000000000003F, 1'b0);
    send_b(3'b000, 32'hFFF00093, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_b((i % 2 == 0) ? 3'b111 : 3'b110, 32'h7FFFFFFF, 5'(i + 4), 64'h0, 1'b1);
    end
    check("b_cnt_saturated", 64'(b_illegal_cnt), 64'd3);

    // Reset with two entries buffered
    a_out_ready = 1'b0;
    send_a(3'b000, 32'hFFF00093, 5'd13, 32'hFFFFFFFF, 1'b0);
    send_a(3'b011, 32'h123450B7, 5'd14, 32'h12345000, 1'b0);
    check("pre_rst_full", 64'(a_in_ready), 64'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(a_out_valid), 64'h0);
    check("mid_rst_in_ready", 64'(a_in_ready), 64'h1);
    check("mid_rst_cnt", 64'(a_illegal_cnt), 64'h0);
    check("mid_rst_imm_out", 64'(a_imm_out), 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    send_a(3'b100, 32'h0010006F, 5'd15, 32'h00000800, 1'b0);
    check("post_rst_latency", 64'(a_out_valid), 64'h1);
    @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
